// File: rtl/param_delay_line.sv
// rtl/param_delay_line.sv - stallable fixed-latency two-channel delay line with valid and occupancy
module param_delay_line #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  localparam int SIZETWO = SIZE - 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [SIZE-1:0]    in1,
  input  logic [SIZETWO-1:0] in2,
  output logic               out_valid,
  output logic [SIZE-1:0]    out1,
  output logic [SIZETWO-1:0] out2,
  output logic [CNT_W-1:0]   level
);

  localparam int DW = SIZE + SIZETWO;

  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]    stage0_d;
  logic [CNT_W-1:0] level_next;

  // Stage-0 load value: MODE=1 loads zero for bubbles so idle stages carry no stale data
  always_comb begin
    stage0_d = {in1, in2};
    if (MODE == 1 && !in_valid) stage0_d = '0;
  end

  // Occupancy moves by one per sample entering or leaving the last stage
  always_comb begin
    level_next = level + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
  end

  // Data stages: flush only clears data in MODE=1, stall holds everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (flush) begin
      if (MODE == 1) begin
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end
    end else if (en) begin
      data_q[0] <= stage0_d;
      for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
    end
  end

  // Valid bits travel alongside the data; flush discards all in-flight samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // Registered occupancy count, updated only on shift edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else if (en) begin
      level <= level_next;
    end
  end

  assign out_valid    = valid_q[DEPTH-1];
  assign {out1, out2} = data_q[DEPTH-1];

  // The incremental count must always agree with the actual number of valid stages
  level_matches_popcount: assert property (
    @(posedge clk) disable iff (!reset_n) level == CNT_W'($countones(valid_q))
  );

endmodule
